// File: rtl/struct_rec_pkg.sv
// ---------------------------------------------------------------------------
// Shared types for struct_rec_packer.
//   pkg1::struct1   - 8-bit first field of a record
//   pkg2::struct1   - 7-bit second field of a record
//   struct_rec_pkg  - local 6-bit third field, the assembled record rec_t,
//                     the framing FSM state enum and REC_W.
// pkg1 and pkg2 both declare struct1, so they are only ever referenced by
// scope (pkg1::struct1 / pkg2::struct1) and never wildcard-imported.
// ---------------------------------------------------------------------------
package pkg1;
    typedef struct packed {
        logic [7:0] data;
    } struct1;
endpackage

package pkg2;
    typedef struct packed {
        logic [6:0] data;
    } struct1;
endpackage

package struct_rec_pkg;
    localparam int REC_W = 21;

    typedef struct packed {
        logic [5:0] data;
    } struct2;

    // Field order fixes the packed layout {first[7:0], second[6:0], third[5:0]}.
    typedef struct packed {
        pkg1::struct1 first;
        pkg2::struct1 second;
        struct2       third;
    } rec_t;

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_THIRD  = 2'd2,
        S_RESYNC = 2'd3
    } state_t;
endpackage

// File: rtl/struct_rec_packer_fifo.sv
// ---------------------------------------------------------------------------
// struct_rec_fifo: rec_t-typed synchronous FIFO.
// Parameters: DEPTH (power of two, >= 2).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   i_push, i_data  - write request and record (ignored when full)
//   i_pop           - read request (ignored when empty)
//   o_data          - head entry, held stable until popped
//   o_full, o_empty - status from registered pointers only
// ---------------------------------------------------------------------------
module struct_rec_fifo
    import struct_rec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  rec_t i_data,
    input  logic i_pop,
    output rec_t o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    rec_t        r_mem [DEPTH];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/struct_rec_packer.sv
// ---------------------------------------------------------------------------
// struct_rec_packer: assembles 3-beat framed byte streams into rec_t records
// and buffers them in a small output FIFO.
// Parameters: DEPTH (FIFO entries, power of two >= 2), CNT_W (counter width).
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last - input beat stream
//   out_valid/out_ready/out_rec - record stream from the FIFO head
//   rec_cnt, drop_cnt           - saturating good / dropped record counters
//   chk_err                     - only with STRUCT_REC_PACKER_CHECK_EN: one
//                                 cycle pulse after a push whose discarded
//                                 bits were not all zero
// Valid/ready: a beat or record transfers on a rising edge where valid and
// ready are both high; valid never waits on ready, and in_ready depends on
// registered state only.
// ---------------------------------------------------------------------------
module struct_rec_packer
    import struct_rec_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output rec_t             out_rec,
    output logic [CNT_W-1:0] rec_cnt,
    output logic [CNT_W-1:0] drop_cnt
`ifdef STRUCT_REC_PACKER_CHECK_EN
    ,
    output logic             chk_err
`endif
);
    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_first;
    logic [6:0]       r_second;
    logic [CNT_W-1:0] r_rec_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic w_accept;
    logic w_push;
    logic w_drop;
    logic w_ld_first;
    logic w_ld_second;
    logic w_full;
    logic w_empty;
    rec_t w_push_rec;

    // Only the third beat can push, so stalling just S_THIRD on full is enough.
    assign in_ready  = !((r_state == S_THIRD) && w_full);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = !w_empty;
    assign rec_cnt   = r_rec_cnt;
    assign drop_cnt  = r_drop_cnt;

    assign w_push_rec.first.data  = r_first;
    assign w_push_rec.second.data = r_second;
    assign w_push_rec.third.data  = in_data[5:0];

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_ld_first   = 1'b0;
        w_ld_second  = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_FIRST: begin
                    w_ld_first = 1'b1;
                    if (in_last) w_drop = 1'b1;
                    else         w_next_state = S_SECOND;
                end
                S_SECOND: begin
                    w_ld_second = 1'b1;
                    if (in_last) begin
                        w_drop       = 1'b1;
                        w_next_state = S_FIRST;
                    end else begin
                        w_next_state = S_THIRD;
                    end
                end
                S_THIRD: begin
                    if (in_last) begin
                        w_push       = 1'b1;
                        w_next_state = S_FIRST;
                    end else begin
                        w_drop       = 1'b1;
                        w_next_state = S_RESYNC;
                    end
                end
                S_RESYNC: begin
                    if (in_last) w_next_state = S_FIRST;
                end
                default: w_next_state = S_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FIRST;
            r_first    <= '0;
            r_second   <= '0;
            r_rec_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ld_first)  r_first  <= in_data;
            if (w_ld_second) r_second <= in_data[6:0];
            if (w_push && (r_rec_cnt != '1))  r_rec_cnt  <= r_rec_cnt + CNT_W'(1);
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

`ifdef STRUCT_REC_PACKER_CHECK_EN
    logic r_disc7;
    logic r_chk_err;

    assign chk_err = r_chk_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disc7   <= 1'b0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_ld_second) r_disc7 <= in_data[7];
            r_chk_err <= w_push && (r_disc7 || (in_data[7:6] != 2'b00));
        end
    end
`endif

    struct_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (out_ready),
        .o_data  (out_rec),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: doc/struct_rec_packer.md
Name: struct_rec_packer

Overview:
- Upstream feeder for the package-struct consumer stage.
- Assembles a 3-byte framed input stream into one record built from three same-shape structs: pkg1::struct1 (8-bit first), pkg2::struct1 (7-bit second) and a locally scoped struct2 (6-bit third).
- Buffers assembled records in a small output FIFO, with valid/ready on both sides.
- Counts good and dropped records.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the rec_cnt and drop_cnt counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  8  input byte
- in_last  in  1  marks the final beat of a record
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head record
- out_rec  out  21  {first[7:0], second[6:0], third[5:0]} as rec_t
- rec_cnt  out  CNT_W  records written to the FIFO
- drop_cnt  out  CNT_W  records discarded for framing errors

Behaviour:
- Reset (async assert, sync deassert): state=S_FIRST, FIFO empty, out_valid=0, out_rec=0, rec_cnt=0, drop_cnt=0, staging registers=0.
- FSM states:
  - S_FIRST: on accept, first<=in_data. If in_last=1, drop the record, drop_cnt++, stay in S_FIRST. Otherwise go to S_SECOND.
  - S_SECOND: on accept, second<=in_data[6:0] (bit 7 discarded). If in_last=1, drop, drop_cnt++, go to S_FIRST. Otherwise go to S_THIRD.
  - S_THIRD: on accept, third<=in_data[5:0] (bits 7:6 discarded). If in_last=1, push {first,second,in_data[5:0]} into the FIFO, rec_cnt++, go to S_FIRST. If in_last=0, drop the record, drop_cnt++, go to S_RESYNC.
  - S_RESYNC: accept and discard beats. Go to S_FIRST on the first accepted beat with in_last=1. No counter change.
- in_ready:
  - 0 in S_THIRD when the FIFO is full; 1 otherwise, including during simultaneous pop.
  - Driven from registered state only; no combinational path from out_ready.
- Latency: the third beat accepted at edge N gives out_valid=1 after edge N when the FIFO was empty. Write-through, no bypass.
- FIFO:
  - Write and read pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Full when the MSBs differ and the remaining bits are equal.
  - Simultaneous push and pop when full: in_ready is already low, so no push occurs.
  - Simultaneous push and pop when empty: out_valid stays 0 in that cycle; the pushed record appears the next cycle.
  - out_rec holds the head entry and is stable while out_valid && !out_ready.
- Counters saturate at all-ones; they never wrap.
- Reset mid-record: the partial record is lost and not counted; FIFO contents are lost.
- in_data is don't-care when in_valid=0. The state machine advances only on accept.

Optional Feature:
- Macro: STRUCT_REC_PACKER_CHECK_EN.
- When defined:
  - Adds output chk_err (1 bit).
  - chk_err pulses high for one cycle after a record push in which the discarded bits (second beat bit 7, third beat bits 7:6) were not all zero.
  - The record is still pushed.
- When undefined: the port does not exist and discarded bits are ignored with no logic.

Decomposition:
- Shared package struct_rec_pkg:
  - typedef rec_t: packed struct of pkg1::struct1, pkg2::struct1 and a struct2 equivalent declared in the package.
  - state enum: S_FIRST, S_SECOND, S_THIRD, S_RESYNC.
  - REC_W=21.
  - pkg1 and pkg2 are referenced only by scope and never wildcard-imported, because both declare struct1.
- Sub-module struct_rec_fifo: a rec_t-typed synchronous FIFO with DEPTH parameter, push/pop/full/empty.

Test Plan:
- Beats 0xFF, 0x7F, 0x3F(last), out_ready=1 -> out_rec={8'hFF,7'h7F,6'h3F}, out_valid one cycle after the 3rd accept, rec_cnt=1.
- Beats 0xAA, 0x80(last) -> drop_cnt=1, no FIFO write, next beat treated as first.
- Beats 0x01, 0x02, 0x03 (no last), 0x04, 0x05(last), then 0x11, 0x22, 0x33(last) -> drop_cnt=1, only {8'h11,7'h22,6'h33} emitted.
- out_ready=0, DEPTH=2, send 3 records -> in_ready=0 in S_THIRD of record 3 until one pop; all three are emitted in order after out_ready=1.
- Assert rst while in S_SECOND with 1 FIFO entry -> all outputs reset immediately (async); the following record is emitted cleanly.
- With STRUCT_REC_PACKER_CHECK_EN: beats 0x00, 0x80, 0xC0(last) -> record {0,0,0} pushed and chk_err=1 for exactly one cycle.
